// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_pkg;

    // Burst sequencer states: ON/OFF alternate during a burst, SETTLE holds the target level.
    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF,
        SETTLE
    } state_e;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 on a left-shifting register.
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Bits needed to hold the longest segment, MIN_HOLD + 2**HOLD_W - 1.
    function automatic int hold_cnt_w(input int min_hold, input int hold_w);
        return $clog2(min_hold + (1 << hold_w));
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; an all-zero seed is replaced by the default seed.
module lfsr16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] lfsr_o
);

    // The all-zero state is a lock-up state, so it can never be used as a start point.
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Shift left, feeding back the XOR of the tapped bits.
    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // State register; shifts every cycle and never halts.
    // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= INIT;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/bounce_emulator.sv
// Turns a clean button level into a bouncing one: each level change becomes a burst of
// 1..2**PAIR_W glitch pairs with pseudo-random segment widths, then a settle period.
module bounce_emulator
    import bounce_pkg::*;
#(
    parameter int          PAIR_W     = 2,
    parameter int          HOLD_W     = 3,
    parameter int          MIN_HOLD   = 2,
    parameter int          SETTLE_CYC = 16,
    parameter logic [15:0] SEED       = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clean,
    input  logic              enable,
    output logic              noisy,
    output logic              busy,
    output logic              settled,
    output logic [PAIR_W:0]   glitches
);

    localparam int HCW = hold_cnt_w(MIN_HOLD, HOLD_W);
    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam int GW  = PAIR_W + 1;

    logic [15:0] lfsr;

    lfsr16 #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lfsr_o (lfsr)
    );

    // Only a few LFSR bits drive timing; the rest are deliberately ignored.
    logic unused_lfsr;
    assign unused_lfsr = ^lfsr;

    // Counters hold "cycles remaining minus one", so a segment of h cycles loads h-1.
    logic [HCW-1:0] hold_load;
    logic [GW-1:0]  pairs_load;
    assign hold_load  = HCW'(MIN_HOLD - 1) + HCW'(lfsr[HOLD_W-1:0]);
    assign pairs_load = GW'(lfsr[8 +: PAIR_W]) + GW'(1);

    state_e         state_q, state_d;
    logic           noisy_q, noisy_d;
    logic           stable_q, stable_d;     // also the burst target while busy
    logic [GW-1:0]  pairs_q, pairs_d;
    logic [GW-1:0]  glitches_q, glitches_d;
    logic [HCW-1:0] hold_q, hold_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic           busy_q, busy_d;
    logic           settled_q, settled_d;

    // Next-state logic: bypass when disabled, otherwise run the burst sequence.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        noisy_d    = noisy_q;
        stable_d   = stable_q;
        pairs_d    = pairs_q;
        glitches_d = glitches_q;
        hold_d     = hold_q;
        settle_d   = settle_q;

        if (!enable) begin
            state_d  = IDLE;
            noisy_d  = clean;
            stable_d = clean;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (clean != stable_q) begin
                        stable_d   = clean;
                        pairs_d    = pairs_load;
                        glitches_d = pairs_load;
                        hold_d     = hold_load;
                        noisy_d    = clean;
                        state_d    = ON;
                    end
                end
                ON: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HCW'(1);
                    end else if (pairs_q == '0) begin
                        settle_d = SCW'(SETTLE_CYC - 1);
                        state_d  = SETTLE;
                    end else begin
                        noisy_d = ~stable_q;
                        hold_d  = hold_load;
                        state_d = OFF;
                    end
                end
                OFF: begin
                    if (hold_q != '0) begin
                        hold_d = hold_q - HCW'(1);
                    end else begin
                        pairs_d = pairs_q - GW'(1);
                        noisy_d = stable_q;
                        hold_d  = hold_load;
                        state_d = ON;
                    end
                end
                SETTLE: begin
                    if (settle_q != '0) begin
                        settle_d = settle_q - SCW'(1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Flags are registered from the next state so outputs never see inputs combinationally.
        busy_d    = (state_d != IDLE);
        settled_d = (state_d == SETTLE) && (settle_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            noisy_q    <= 1'b0;
            stable_q   <= 1'b0;
            pairs_q    <= '0;
            glitches_q <= '0;
            hold_q     <= '0;
            settle_q   <= '0;
            busy_q     <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            noisy_q    <= noisy_d;
            stable_q   <= stable_d;
            pairs_q    <= pairs_d;
            glitches_q <= glitches_d;
            hold_q     <= hold_d;
            settle_q   <= settle_d;
            busy_q     <= busy_d;
            settled_q  <= settled_d;
        end
    end

    assign noisy    = noisy_q;
    assign busy     = busy_q;
    assign settled  = settled_q;
    assign glitches = glitches_q;

endmodule

// File: doc/bounce_emulator.md
Name: bounce_emulator

Overview:
Synthesizable mechanical-switch emulator: converts a clean level (`clean`) into a realistically bouncing `noisy` signal. Each bounce burst has a pseudo-random number of glitches and pseudo-random glitch widths. It is the driving end of the team's push-button input path and feeds debouncer blocks on-board, for self-test without physical buttons. Bounce timing comes from an internal 16-bit LFSR, so runs are reproducible from `SEED`.

Parameters:
- `PAIR_W`, default 2: glitches per burst = 1..2**PAIR_W.
- `HOLD_W`, default 3: random width field; each segment lasts `MIN_HOLD` + 0..2**HOLD_W-1 cycles.
- `MIN_HOLD`, default 2: minimum segment length in cycles; must be ≥1.
- `SETTLE_CYC`, default 16: cycles `noisy` is held stable at target after the last glitch; must be ≥1.
- `SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.

Ports:
- `clk`  in  1  system clock, all logic on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clean`  in  1  ideal button level; must already be synchronous to `clk`.
- `enable`  in  1  1 = emulate bounce; 0 = bypass (noisy follows clean).
- `noisy`  out  1  registered bouncing output.
- `busy`  out  1  high while a burst or settle is in progress.
- `settled`  out  1  one-cycle pulse when the settle period completes.
- `glitches`  out  PAIR_W+1  glitch count of the current/last burst.

Behaviour:
- Reset (async assert, sync release): state=IDLE, `noisy`=0, stable_level=0, `busy`=0, `settled`=0, `glitches`=0, lfsr=SEED (or 16'hACE1 if SEED==0), counters=0.
- LFSR: Fibonacci x^16+x^14+x^13+x^11+1. Shifts every cycle, never halts. Only bits [HOLD_W-1:0] (hold) and [8+PAIR_W-1:8] (pair count) are consumed.
- Segment length h = MIN_HOLD + lfsr[HOLD_W-1:0], sampled at segment entry. The hold counter is wide enough for MIN_HOLD+2**HOLD_W-1.
- FSM states: IDLE, ON, OFF, SETTLE.
  - IDLE: `busy`=0. When `clean` != stable_level and `enable`=1 in cycle t:
    - target=clean, stable_level=clean.
    - pairs_left = lfsr[8+PAIR_W-1:8]+1, and `glitches` is loaded with the same value.
    - Load h, go ON.
    - `noisy`=target from cycle t+1; `busy`=1 from t+1.
  - ON: `noisy`=target for exactly h cycles.
    - If pairs_left==0, go SETTLE.
    - Otherwise go OFF with `noisy`=~target and a fresh h.
  - OFF: `noisy`=~target for exactly h cycles, then pairs_left-=1, go ON with `noisy`=target and a fresh h.
  - SETTLE: `noisy`=target for SETTLE_CYC cycles. On the last cycle, `settled` pulses for 1 cycle and the FSM returns to IDLE; `busy`=0 the following cycle.
- A burst therefore has exactly 2*glitches+1 transitions on `noisy`, and `noisy` always ends at target.
- `clean` changes while busy are ignored. On return to IDLE the compare re-evaluates, so a press released mid-burst starts a new burst immediately. No event is lost; the final level always matches `clean`.
- `enable`=0:
  - Any state goes to IDLE next cycle; `noisy` <= `clean` each cycle (1-cycle latency); stable_level <= `clean`.
  - `busy`=0, and an aborted burst does not pulse `settled`.
  - `glitches` keeps its last value.
- `enable` rising while `clean`==stable_level: no burst.
- Reset asserted mid-burst: all state returns immediately to reset values; `noisy` goes to 0 asynchronously.
- Single clock domain; no combinational path from inputs to outputs.

Decomposition:
- Package `bounce_pkg`:
  - state enum {IDLE, ON, OFF, SETTLE}
  - LFSR tap mask 16'hB400
  - default seed 16'hACE1
  - function computing counter width from MIN_HOLD/HOLD_W
- Sub-module `lfsr16`:
  - Ports: clk, rst_n, seed param, 16-bit state output.
  - Free-running; reused by other stimulus blocks.

Test Plan:
- Reset: `rst_n`=0 for 3 cycles with `clean`=1, `enable`=1 → `noisy`=0, `busy`=0, `glitches`=0; after release, a burst starts on the first post-reset cycle.
- Bypass, `enable`=0: `clean` 0→1 at cycle 10 → `noisy`=1 at cycle 11, no further toggles, `busy` never high.
- One press, defaults: `clean` 0→1 and held →
  - `noisy` toggles exactly 2*`glitches`+1 times, with `glitches` in 1..4;
  - every segment length in 2..9 cycles;
  - then stable 1 for 16 cycles, a 1-cycle `settled` pulse, `busy` falls.
- Reproducibility: two runs with the same SEED and stimulus produce identical `noisy` traces; SEED=0 gives the same trace as SEED=16'hACE1.
- Release during burst: `clean` 0→1, then 1→0 while `busy`=1 → first burst completes at 1; the next cycle after IDLE starts a second burst ending at 0 and a second `settled` pulse.
- Abort: deassert `enable` in the OFF state → next cycle `noisy`=`clean`, `busy`=0, no `settled` pulse; re-enabling with an unchanged `clean` produces no burst.
